// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, column drive
// patterns and the {col,row} -> hex code map.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } kp_state_e;

   // Active-low column drive, indexed by column number.
   localparam logic [3:0][3:0] COL_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Indexed by {col,row}; entry 0 is col0/row0.
   localparam logic [15:0][3:0] CODE_MAP = {
      4'hD, 4'hC, 4'hB, 4'hA,   // col3
      4'hE, 4'h9, 4'h6, 4'h3,   // col2
      4'hF, 4'h8, 4'h5, 4'h2,   // col1
      4'h0, 4'h7, 4'h4, 4'h1    // col0
   };

   function automatic logic [2:0] count_low(input logic [3:0] r);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, ~r[i]};
      return n;
   endfunction

endpackage

// File: rtl/keypad_col_seq.sv
// Column sequencer: dwell divider, column index and registered active-low
// column drive, plus a one-cycle sample pulse on the dwell terminal count.
module keypad_col_seq
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1250
) (
   input  logic       clk_i,
   input  logic       reset_i,
   output logic [3:0] cols_o,
   output logic [1:0] index_o,
   output logic       sample_o
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    cols_q;
   logic          tc;

   assign tc = (div_q == DW'(SCAN_DIV - 1));

   always_comb begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (tc) begin
         div_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // cols is registered from the next index so it never glitches.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q  <= '0;
         idx_q  <= 2'd0;
         cols_q <= COL_PAT[0];
      end else begin
         div_q  <= div_d;
         idx_q  <= idx_d;
         cols_q <= COL_PAT[idx_d];
      end
   end

   assign cols_o   = cols_q;
   assign index_o  = idx_q;
   assign sample_o = tc;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner/debouncer with hex code, level valid and press strobe.
// Optional auto-repeat of the strobe while held: define KEYPAD_REPEAT_EN.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1250,
   parameter int unsigned DEBOUNCE_SCANS = 200,
   parameter int unsigned REPEAT_SCANS   = 2000
) (
   input  logic       x1,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_strobe
);

   logic [3:0] rows_m_q, rows_s_q;
   logic [1:0] col_idx;
   logic       sample;

   logic [1:0] acc_cnt_q, acc_cnt_d;
   logic [3:0] acc_code_q, acc_code_d;
   logic [1:0] col_row;
   logic       hit_any;
   logic [2:0] tot;

   logic       scan_done_q, scan_hit_q;
   logic [3:0] scan_code_q;

   kp_state_e  state_q;
   logic [3:0] cand_q;
   logic [7:0] cnt_q;
   logic [3:0] key_code_q;
   logic       key_valid_q, key_strobe_q;

   keypad_col_seq #(.SCAN_DIV(SCAN_DIV)) u_col_seq (
      .clk_i    (x1),
      .reset_i  (reset),
      .cols_o   (cols),
      .index_o  (col_idx),
      .sample_o (sample)
   );

   always_ff @(posedge x1) begin
      if (reset) begin
         rows_m_q <= 4'hF;
         rows_s_q <= 4'hF;
      end else begin
         rows_m_q <= rows;
         rows_s_q <= rows_m_q;
      end
   end

   // Hit count saturates at 2: anything above one key is rejected anyway.
   always_comb begin
      col_row = 2'd0;
      hit_any = 1'b0;
      for (int r = 0; r < 4; r++) begin
         if (!rows_s_q[r]) begin
            col_row = 2'(r);
            hit_any = 1'b1;
         end
      end
      tot        = {1'b0, acc_cnt_q} + count_low(rows_s_q);
      acc_cnt_d  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
      acc_code_d = hit_any ? CODE_MAP[{col_idx, col_row}] : acc_code_q;
   end

   always_ff @(posedge x1) begin
      if (reset) begin
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'h0;
         scan_done_q <= 1'b0;
         scan_hit_q  <= 1'b0;
         scan_code_q <= 4'h0;
      end else begin
         scan_done_q <= 1'b0;
         if (sample) begin
            if (col_idx == 2'd3) begin
               acc_cnt_q   <= 2'd0;
               acc_code_q  <= 4'h0;
               scan_done_q <= 1'b1;
               scan_hit_q  <= (acc_cnt_d == 2'd1);
               scan_code_q <= acc_code_d;
            end else begin
               acc_cnt_q  <= acc_cnt_d;
               acc_code_q <= acc_code_d;
            end
         end
      end
   end

`ifdef KEYPAD_REPEAT_EN
   logic [15:0] rep_q;
`endif

   always_ff @(posedge x1) begin
      if (reset) begin
         state_q      <= IDLE;
         cand_q       <= 4'h0;
         cnt_q        <= 8'd0;
         key_code_q   <= 4'h0;
         key_valid_q  <= 1'b0;
         key_strobe_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q        <= 16'd0;
`endif
      end else begin
         key_strobe_q <= 1'b0;
         if (scan_done_q) begin
            case (state_q)
               IDLE: begin
                  if (scan_hit_q) begin
                     cand_q <= scan_code_q;
                     cnt_q  <= 8'd1;
                     if (DEBOUNCE_SCANS == 1) begin
                        state_q      <= PRESSED;
                        key_code_q   <= scan_code_q;
                        key_valid_q  <= 1'b1;
                        key_strobe_q <= 1'b1;
                     end else begin
                        state_q <= DEB_PRESS;
                     end
                  end
               end
               DEB_PRESS: begin
                  if (!scan_hit_q) begin
                     state_q <= IDLE;
                  end else if (scan_code_q != cand_q) begin
                     cand_q <= scan_code_q;
                     cnt_q  <= 8'd1;
                  end else if (cnt_q == 8'(DEBOUNCE_SCANS - 1)) begin
                     state_q      <= PRESSED;
                     key_code_q   <= cand_q;
                     key_valid_q  <= 1'b1;
                     key_strobe_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               PRESSED: begin
                  if (scan_hit_q && scan_code_q == key_code_q) begin
`ifdef KEYPAD_REPEAT_EN
                     if (rep_q == 16'(REPEAT_SCANS - 1)) begin
                        rep_q        <= 16'd0;
                        key_strobe_q <= 1'b1;
                     end else begin
                        rep_q <= rep_q + 16'd1;
                     end
`endif
                  end else begin
                     cnt_q <= 8'd1;
`ifdef KEYPAD_REPEAT_EN
                     rep_q <= 16'd0;
`endif
                     if (DEBOUNCE_SCANS == 1) begin
                        state_q     <= IDLE;
                        key_valid_q <= 1'b0;
                     end else begin
                        state_q <= DEB_RELEASE;
                     end
                  end
               end
               DEB_RELEASE: begin
                  if (scan_hit_q && scan_code_q == key_code_q) begin
                     state_q <= PRESSED;
                  end else if (cnt_q == 8'(DEBOUNCE_SCANS - 1)) begin
                     state_q     <= IDLE;
                     key_valid_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign key_code   = key_code_q;
   assign key_valid  = key_valid_q;
   assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a combinational keypad matrix model.
module tb_keypad_scan;

   logic       x1 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows, cols, key_code;
   logic       key_valid, key_strobe;
   logic [15:0] held = 16'h0000;   // bit index col*4+row

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   localparam logic [15:0] NONE = 16'h0000;
   localparam logic [15:0] K1   = 16'h0001;   // col0 row0
   localparam logic [15:0] K2   = 16'h0010;   // col1 row0
   localparam logic [15:0] K5   = 16'h0020;   // col1 row1
   localparam logic [15:0] K6   = 16'h0200;   // col2 row1
   localparam logic [15:0] K9   = 16'h0400;   // col2 row2
   localparam logic [15:0] KA   = 16'h1000;   // col3 row0

   always #5 x1 = ~x1;

   keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(4)) dut (
      .x1(x1), .reset(reset), .rows(rows), .cols(cols),
      .key_code(key_code), .key_valid(key_valid), .key_strobe(key_strobe)
   );

   always_comb begin
      rows = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!cols[c] && held[c*4+r]) rows[r] = 1'b0;
   end

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Every strobe is matched against the scoreboard queue.
   task automatic tick();
      logic [3:0] e;
      @(negedge x1);
      if (key_strobe !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got strobe code %h expected none", key_code);
         end else begin
            e = exp_q.pop_front();
            if (key_code !== e) begin
               errors++;
               $display("FAIL strobe_code: got %h expected %h", key_code, e);
            end
         end
      end
   endtask

   task automatic scans(input int n);
      repeat (n * 32) tick();
   endtask

   task automatic drain(input string nm);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d strobes outstanding expected 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   typedef struct {
      logic [15:0] keys;
      int          n;
      logic        valid;
      logic [3:0]  code;
      logic        push;
   } vec_t;

   vec_t vt[18];
   logic [3:0] pat[4];

   initial begin
      vt[0]  = '{K6,      2, 1'b0, 4'h0, 1'b0};
      vt[1]  = '{K6,      1, 1'b1, 4'h6, 1'b1};
      vt[2]  = '{K6,      2, 1'b1, 4'h6, 1'b0};
      vt[3]  = '{NONE,    2, 1'b1, 4'h6, 1'b0};
      vt[4]  = '{NONE,    1, 1'b0, 4'h6, 1'b0};
      vt[5]  = '{K9,      2, 1'b0, 4'h6, 1'b0};
      vt[6]  = '{NONE,    1, 1'b0, 4'h6, 1'b0};
      vt[7]  = '{K9,      2, 1'b0, 4'h6, 1'b0};
      vt[8]  = '{K9,      1, 1'b1, 4'h9, 1'b1};
      vt[9]  = '{NONE,    3, 1'b0, 4'h9, 1'b0};
      vt[10] = '{K1 | K5, 4, 1'b0, 4'h9, 1'b0};
      vt[11] = '{K1,      2, 1'b0, 4'h9, 1'b0};
      vt[12] = '{K1,      1, 1'b1, 4'h1, 1'b1};
      vt[13] = '{NONE,    3, 1'b0, 4'h1, 1'b0};
      vt[14] = '{K2,      3, 1'b1, 4'h2, 1'b1};
      vt[15] = '{NONE,    1, 1'b1, 4'h2, 1'b0};
      vt[16] = '{K2,      1, 1'b1, 4'h2, 1'b0};
      vt[17] = '{NONE,    3, 1'b0, 4'h2, 1'b0};
      pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

      // Reset state
      repeat (3) tick();
      check("rst_cols", cols, 4'b1110);
      check("rst_code", key_code, 4'h0);
      check("rst_valid", {3'b0, key_valid}, 4'h0);
      check("rst_strobe", {3'b0, key_strobe}, 4'h0);

      // Release; two ticks puts us at cycle 2 of scan 0.
      reset = 1'b0;
      tick(); tick();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("cols_seq%0d", i), cols, pat[i % 4]);
         repeat (8) tick();
      end
      for (int i = 0; i < 18; i++) begin
         scans(1);
         check("idle_valid", {3'b0, key_valid}, 4'h0);
      end

      for (int i = 0; i < 18; i++) begin
         held = vt[i].keys;
         if (vt[i].push) exp_q.push_back(vt[i].code);
         scans(vt[i].n);
         check($sformatf("vec%0d_valid", i), {3'b0, key_valid}, {3'b0, vt[i].valid});
         check($sformatf("vec%0d_code", i), key_code, vt[i].code);
         drain($sformatf("vec%0d_strobe_missing", i));
      end

      // Reset in the middle of debouncing key A discards the partial count.
      held = KA;
      scans(2);
      reset = 1'b1;
      repeat (3) tick();
      check("mid_rst_cols", cols, 4'b1110);
      check("mid_rst_code", key_code, 4'h0);
      check("mid_rst_valid", {3'b0, key_valid}, 4'h0);
      check("mid_rst_strobe", {3'b0, key_strobe}, 4'h0);
      reset = 1'b0;
      tick(); tick();
      scans(2);
      check("a_not_yet", {3'b0, key_valid}, 4'h0);
      drain("a_early");
      exp_q.push_back(4'hA);
      scans(1);
      check("a_valid", {3'b0, key_valid}, 4'h1);
      check("a_code", key_code, 4'hA);
      drain("a_strobe_missing");
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 2; i++) begin
         scans(3);
         drain("a_repeat_early");
         exp_q.push_back(4'hA);
         scans(1);
         drain("a_repeat_missing");
      end
`else
      scans(8);
`endif
      check("a_hold_valid", {3'b0, key_valid}, 4'h1);
      held = NONE;
      scans(3);
      check("a_rel_valid", {3'b0, key_valid}, 4'h0);
      check("a_rel_code", key_code, 4'hA);
      drain("final_strobes");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner and debouncer for a 4x4 hex matrix keypad (Pmod KYPD style) on the Spartan 6 board. It is the input-side counterpart of the multiplexed seven-segment display driver: it drives columns one at a time, reads rows, and resolves a single debounced key. It delivers a 4-bit hex code with a level-valid flag and a one-cycle press strobe to downstream logic running on the 100 MHz crystal clock.

## Interface
- SCAN_DIV, 1250: clocks per column dwell; one full scan is 4*SCAN_DIV clocks (50 us at 100 MHz). Legal range ≥ 8.
- DEBOUNCE_SCANS, 200: consecutive identical full scans required to accept a press or release (10 ms default). Legal range 1..255.
- REPEAT_SCANS, 2000: auto-repeat interval in full scans. Used only with KEYPAD_REPEAT_EN. Legal range 1..65535.
- x1  input  1  system clock, 100 MHz crystal
- reset  input  1  synchronous, active-high reset
- rows  input  4  keypad row lines, active-low, asynchronous to x1, externally pulled up
- cols  output  4  keypad column drive, active-low, exactly one bit low at all times
- key_code  output  4  hex code of the current or last accepted key
- key_valid  output  1  high while a debounced key is held
- key_strobe  output  1  one-cycle pulse per accepted press (and per repeat when enabled)

## Operation
- rows pass through a 2-flop synchronizer.
- Column sequencer:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count, column index advances 0→1→2→3→0.
  - cols = ~(1 << index).
- Sample point: the synchronized rows are sampled on the terminal-count cycle, before the column advances. This leaves SCAN_DIV-3 clocks of settling time.
- Per-scan accumulation:
  - Count the low row bits across all four columns.
  - Record the code of the last hit.
  - At the column-3 sample, the scan result is "single key + code" when the count is exactly 1. A count of 0 or ≥2 is "no key"; ghosting and multi-press are rejected.
- Code map by column/row 0..3:
  - col0 → 1,4,7,0
  - col1 → 2,5,8,F
  - col2 → 3,6,9,E
  - col3 → A,B,C,D
- FSM, evaluated once per completed scan:
  - IDLE: on a single-key result, load cand=code, cnt=1, go to DEB_PRESS. If DEBOUNCE_SCANS=1, accept immediately.
  - DEB_PRESS:
    - Same code: cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED, set key_code=cand, key_valid=1, pulse key_strobe.
    - Different code: restart with the new cand and cnt=1.
    - No key: return to IDLE.
  - PRESSED: a result other than the same code starts DEB_RELEASE with cnt=1. The same code holds the state.
  - DEB_RELEASE:
    - Same code as key_code: return to PRESSED.
    - Otherwise cnt++. At DEBOUNCE_SCANS, go to IDLE with key_valid=0. key_code retains its value.

## Timing
- Reset values:
  - cols=4'b1110, index 0, divider 0
  - key_code=0, key_valid=0, key_strobe=0
  - FSM=IDLE, counters 0, accumulators cleared
- Reset mid-scan or mid-debounce discards all partial state. The next scan restarts at column 0.
- A row change reaches the sample after 2 clocks of synchronizer latency.
- Outputs register on the edge following the column-3 sample edge. From the end-of-scan sample edge, key_valid and key_strobe change one clock later.
- key_strobe is high for exactly one x1 cycle.
- key_valid and key_code change together.
- Minimum press latency ≈ DEBOUNCE_SCANS*4*SCAN_DIV + 4*SCAN_DIV clocks.
- Divider and column index wrap silently. There are no error outputs.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a 16-bit scan counter starts at 0 on entry.
  - Every REPEAT_SCANS scans it pulses key_strobe, with code unchanged.
  - The counter clears on leaving PRESSED.
- Not defined: no repeat counter is built. Exactly one strobe per press.

## Structure
- Package keypad_pkg holds:
  - the 16-entry code map constant indexed by {col,row}
  - the FSM state encoding (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE)
  - the active-low column pattern constants
- One sub-module: keypad_col_seq. It holds the divider and column index, and outputs cols, index and the sample pulse.
- Synchronizer, accumulator and FSM stay in the top level.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE_SCANS=3, REPEAT_SCANS=4.
- Reset released, no key: cols cycles 1110→1101→1011→0111 every 8 clocks. key_valid=0 and no strobe for 20 scans.
- Hold rows=1101 only while cols=1011 (key 6): after 3 scans, exactly one key_strobe. key_code=6 and key_valid=1 while held.
- Release key 6: key_valid falls after 3 empty scans. key_code stays 6. No strobe.
- Bounce: key 9 present 2 scans, absent 1, present 3 → a single strobe, issued only after the final 3-scan run.
- Keys 1 and 5 pressed together: no strobe and key_valid stays 0. Release key 5 → key 1 accepted after 3 scans.
- Assert reset during DEB_PRESS for key A: outputs return to reset values. Then with KEYPAD_REPEAT_EN, hold A → strobe, then a further strobe every 4 scans while held.
